// File: rtl/axi_sram_bridge_pkg.sv
// Shared types, response codes and burst address stepping for axi_sram_bridge.
package axi_sram_bridge_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'd0,
    INCR  = 2'd1,
    WRAP  = 2'd2
  } burst_e;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] SLVERR = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    WDATA,
    WRESP,
    RDATA
  } state_e;

  // Computed at 64 bits; callers truncate, which gives the modulo-2^AddressWidth wrap.
  function automatic logic [63:0] next_addr(input logic [63:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst,
                                            input logic [7:0]  len);
    logic [63:0] step;
    logic [63:0] incr;
    logic [63:0] mask;
    logic [63:0] res;
    step = 64'd1 << size;
    incr = (addr & ~(step - 64'd1)) + step;
    mask = ((64'(len) + 64'd1) << size) - 64'd1;
    res  = addr;
    case (burst)
      INCR:    res = incr;
      WRAP:    res = (addr & ~mask) | (incr & mask);
      default: res = addr;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/axi_sram_rd_buf.sv
// Two-entry FIFO holding {data, last, resp} read beats between the SRAM and the AXI R channel.
module axi_sram_rd_buf #(
  parameter int DataWidth = 64
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DataWidth-1:0] in_data,
  input  logic                 in_last,
  input  logic [1:0]           in_resp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DataWidth-1:0] out_data,
  output logic                 out_last,
  output logic [1:0]           out_resp
);

  localparam int EntryW = DataWidth + 3;

  logic [EntryW-1:0] ent_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        cnt_q;
  logic              push;
  logic              pop;

  assign in_ready  = (cnt_q != 2'd2);
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign {out_data, out_last, out_resp} = ent_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q] <= {in_data, in_last, in_resp};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/axi_sram_bridge.sv
// AXI4 subordinate turning single bursts into single-port SRAM accesses.
// Define AXI_SRAM_BRIDGE_WRAP_EN to support WRAP bursts; otherwise WRAP answers SLVERR.
//
// state | meaning
// IDLE  | arbitrating AW/AR, registered ready for the chosen channel
// WDATA | accepting write beats, one SRAM write per beat
// WRESP | holding the B response until bready
// RDATA | issuing SRAM reads and returning R beats from the read buffer
module axi_sram_bridge
  import axi_sram_bridge_pkg::*;
#(
  parameter int AddressWidth = 20,
  parameter int DataWidth    = 64,
  parameter int IdWidth      = 8,
  localparam int ByteShift    = $clog2(DataWidth / 8),
  localparam int MemAddrWidth = AddressWidth - ByteShift
) (
  input  logic                    clk,
  input  logic                    areset_n,
  input  logic [IdWidth-1:0]      awid,
  input  logic [AddressWidth-1:0] awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DataWidth-1:0]    wdata,
  input  logic [DataWidth/8-1:0]  wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [IdWidth-1:0]      bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [IdWidth-1:0]      arid,
  input  logic [AddressWidth-1:0] araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [IdWidth-1:0]      rid,
  output logic [DataWidth-1:0]    rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready,
  output logic [MemAddrWidth-1:0] mem_addr,
  output logic                    mem_we,
  output logic [DataWidth/8-1:0]  mem_wstrb,
  output logic [DataWidth-1:0]    mem_wdata,
  output logic                    mem_re,
  input  logic [DataWidth-1:0]    mem_rdata
);

`ifdef AXI_SRAM_BRIDGE_WRAP_EN
  localparam bit WrapEn = 1'b1;
`else
  localparam bit WrapEn = 1'b0;
`endif

  state_e                  state_q, state_d;
  logic                    awready_q, arready_q, last_wr_q;
  logic [IdWidth-1:0]      id_q;
  logic [AddressWidth-1:0] addr_q, addr_nxt;
  logic [7:0]              len_q, cnt_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic                    err_q, done_q, infl_q, infl_last_q;
  logic                    aw_hs, ar_hs, w_hs, rd_pop, issue, buf_in_ready;
  logic [1:0]              occ;
  logic                    unused_wlast;

  function automatic logic bad_req(input logic [2:0] size, input logic [1:0] burst,
                                   input logic [7:0] len);
    logic wrap_ok;
    wrap_ok = WrapEn && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (int'(size) > ByteShift) || (burst == 2'b11) || (burst == WRAP && !wrap_ok);
  endfunction

  assign unused_wlast = wlast;

  assign aw_hs    = awvalid && awready_q;
  assign ar_hs    = arvalid && arready_q;
  assign awready  = awready_q;
  assign arready  = arready_q;
  assign wready   = (state_q == WDATA);
  assign w_hs     = wvalid && wready;
  assign bvalid   = (state_q == WRESP);
  assign bid      = id_q;
  assign bresp    = (bvalid && err_q) ? SLVERR : OKAY;
  assign rid      = id_q;
  assign rd_pop   = rvalid && rready;
  assign addr_nxt = AddressWidth'(next_addr(64'(addr_q), size_q, burst_q, len_q));

  // Count the beat leaving this cycle so the read pipe keeps 1 beat/cycle.
  assign occ   = !buf_in_ready ? 2'd2 : {1'b0, rvalid};
  assign issue = (state_q == RDATA) && !done_q &&
                 ((3'(occ) + 3'(infl_q)) < (3'd2 + 3'(rd_pop)));

  assign mem_addr  = addr_q[AddressWidth-1:ByteShift];
  assign mem_we    = w_hs && !err_q;
  assign mem_wstrb = mem_we ? wstrb : '0;
  assign mem_wdata = mem_we ? wdata : '0;
  assign mem_re    = issue && !err_q;

  axi_sram_rd_buf #(.DataWidth(DataWidth)) u_rd_buf (
    .clk       (clk),
    .areset_n  (areset_n),
    .in_valid  (infl_q),
    .in_ready  (buf_in_ready),
    .in_data   (err_q ? '0 : mem_rdata),
    .in_last   (infl_last_q),
    .in_resp   (err_q ? SLVERR : OKAY),
    .out_valid (rvalid),
    .out_ready (rready),
    .out_data  (rdata),
    .out_last  (rlast),
    .out_resp  (rresp)
  );

  always_ff @(posedge clk) begin
    if (!areset_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (aw_hs) state_d = WDATA; else if (ar_hs) state_d = RDATA;
      WDATA:   if (w_hs && cnt_q == 8'd0) state_d = WRESP;
      WRESP:   if (bready) state_d = IDLE;
      RDATA:   if (rd_pop && rlast) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!areset_n) begin
      awready_q   <= 1'b0;
      arready_q   <= 1'b0;
      last_wr_q   <= 1'b0;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
    end else begin
      if (state_q == IDLE) begin
        if (aw_hs || ar_hs) begin
          awready_q <= 1'b0;
          arready_q <= 1'b0;
          last_wr_q <= aw_hs;
          id_q      <= aw_hs ? awid    : arid;
          addr_q    <= aw_hs ? awaddr  : araddr;
          len_q     <= aw_hs ? awlen   : arlen;
          cnt_q     <= aw_hs ? awlen   : arlen;
          size_q    <= aw_hs ? awsize  : arsize;
          burst_q   <= aw_hs ? awburst : arburst;
          err_q     <= aw_hs ? bad_req(awsize, awburst, awlen) : bad_req(arsize, arburst, arlen);
          done_q    <= 1'b0;
        end else if (!awready_q && !arready_q) begin
          // Ties go to the channel that was not served last.
          if (awvalid && (!arvalid || !last_wr_q)) awready_q <= 1'b1;
          else if (arvalid)                        arready_q <= 1'b1;
        end
      end
      if (w_hs) begin
        if (cnt_q != 8'd0) cnt_q <= cnt_q - 8'd1;
        addr_q <= addr_nxt;
      end
      if (issue) begin
        if (cnt_q == 8'd0) done_q <= 1'b1;
        else               cnt_q  <= cnt_q - 8'd1;
        addr_q <= addr_nxt;
      end
      infl_q      <= issue;
      infl_last_q <= issue && (cnt_q == 8'd0);
    end
  end

endmodule

// File: tb/tb_axi_sram_bridge.sv
// Directed bench for axi_sram_bridge (DataWidth=64) with a behavioural SRAM and reference memory.
module tb_axi_sram_bridge;

  logic        clk = 1'b0;
  logic        areset_n = 1'b0;
  logic [7:0]  awid = '0, arid = '0;
  logic [19:0] awaddr = '0, araddr = '0;
  logic [7:0]  awlen = '0, arlen = '0;
  logic [2:0]  awsize = '0, arsize = '0;
  logic [1:0]  awburst = '0, arburst = '0;
  logic        awvalid = 1'b0, arvalid = 1'b0;
  logic        awready, arready;
  logic [63:0] wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        wlast = 1'b0, wvalid = 1'b0, wready;
  logic [7:0]  bid, rid;
  logic [1:0]  bresp, rresp;
  logic        bvalid, bready = 1'b0;
  logic [63:0] rdata;
  logic        rlast, rvalid, rready = 1'b0;
  logic [16:0] mem_addr;
  logic        mem_we, mem_re;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata, mem_rdata = '0;

  int n_chk = 0, n_fail = 0;
  int cyc = 0, stab_err = 0, bv_cnt = 0;
  logic        stall_q = 1'b0;
  logic [63:0] stall_d = '0;
  logic [63:0] sram  [256];
  logic [63:0] model [256];

  logic [16:0] re_q[$], we_a[$];
  logic [63:0] we_d[$], rd_d[$];
  logic [7:0]  we_s[$], b_id[$], rd_i[$];
  logic [1:0]  rd_r[$], b_r[$];
  logic        rd_l[$];
  int          rd_c[$];

  axi_sram_bridge dut (
    .clk(clk), .areset_n(areset_n),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 8; b++)
        if (mem_wstrb[b]) sram[mem_addr[7:0]][8*b +: 8] = mem_wdata[8*b +: 8];
    if (mem_re) mem_rdata <= sram[mem_addr[7:0]];
  end

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (areset_n) begin
      if (mem_re) re_q.push_back(mem_addr);
      if (mem_we) begin
        we_a.push_back(mem_addr); we_d.push_back(mem_wdata); we_s.push_back(mem_wstrb);
      end
      if (rvalid && rready) begin
        rd_d.push_back(rdata); rd_r.push_back(rresp); rd_l.push_back(rlast);
        rd_c.push_back(cyc); rd_i.push_back(rid);
      end
      if (bvalid) bv_cnt = bv_cnt + 1;
      if (bvalid && bready) begin b_id.push_back(bid); b_r.push_back(bresp); end
      if (stall_q && (!rvalid || rdata != stall_d)) stab_err = stab_err + 1;
      stall_q = rvalid && !rready;
      stall_d = rdata;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pat(input int i);
    return {32'hC0DE0000 + 32'(i), 32'h10000000 + 32'(i)};
  endfunction

  task automatic clear();
    re_q.delete(); we_a.delete(); we_d.delete(); we_s.delete();
    rd_d.delete(); rd_r.delete(); rd_l.delete(); rd_c.delete(); rd_i.delete();
    b_id.delete(); b_r.delete();
    bv_cnt = 0; stab_err = 0;
  endtask

  task automatic aw_send(input logic [19:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [7:0] id);
    bit ok = 0;
    awaddr = a; awlen = len; awsize = sz; awburst = bu; awid = id; awvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (awready) begin ok = 1; break; end
      tick();
    end
    tick();
    awvalid = 1'b0;
    if (!ok) chk("aw_timeout", 0, 1);
  endtask

  task automatic ar_send(input logic [19:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [7:0] id);
    bit ok = 0;
    araddr = a; arlen = len; arsize = sz; arburst = bu; arid = id; arvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (arready) begin ok = 1; break; end
      tick();
    end
    tick();
    arvalid = 1'b0;
    if (!ok) chk("ar_timeout", 0, 1);
  endtask

  task automatic w_beat(input logic [63:0] d, input logic [7:0] s, input logic l);
    bit ok = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (wready) begin ok = 1; break; end
      tick();
    end
    tick();
    wvalid = 1'b0; wlast = 1'b0;
    if (!ok) chk("w_timeout", 0, 1);
  endtask

  task automatic wait_b();
    bit ok = 0;
    bready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (bvalid) begin ok = 1; break; end
      tick();
    end
    tick();
    bready = 1'b0;
    if (!ok) chk("b_timeout", 0, 1);
  endtask

  task automatic collect_r(input int n, input bit toggle);
    for (int k = 0; k < 100; k++) begin
      if (rd_d.size() >= n) break;
      rready = toggle ? (k % 2 == 0) : 1'b1;
      tick();
    end
    rready = 1'b0;
    chk("r_beat_count", 64'(rd_d.size()), 64'(n));
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_ctl"}, {awready, wready, arready, bvalid, rvalid, rlast, mem_we, mem_re}, 0);
    chk({tag, "_ids"}, {bid, rid, bresp, rresp}, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_mem"}, {mem_addr, mem_wstrb}, 0);
    chk({tag, "_wdata"}, mem_wdata, 0);
  endtask

  task automatic chk_incr_read(input string tag, input bit consecutive);
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_addr"}, re_q[i], 17'h20 + 17'(i));
      chk({tag, "_data"}, rd_d[i], model[8'h20 + i]);
      chk({tag, "_last"}, rd_l[i], i == 3);
      chk({tag, "_resp"}, rd_r[i], 2'd0);
      if (consecutive) chk({tag, "_cycle"}, 64'(rd_c[i]), 64'(rd_c[0] + i));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin sram[i] = pat(i); model[i] = pat(i); end
    repeat (3) tick();
    chk_zero_outs("reset");
    areset_n = 1'b1;
    tick();

    // 1: single-beat write
    clear();
    aw_send(20'h100, 8'd0, 3'd3, 2'd1, 8'd5);
    w_beat(64'h1122334455667788, 8'hFF, 1'b1);
    model[8'h20] = 64'h1122334455667788;
    wait_b();
    chk("t1_we_cnt", 64'(we_a.size()), 1);
    chk("t1_we_addr", we_a[0], 17'h20);
    chk("t1_we_data", we_d[0], 64'h1122334455667788);
    chk("t1_we_strb", we_s[0], 8'hFF);
    chk("t1_bid", b_id[0], 8'd5);
    chk("t1_bresp", b_r[0], 2'd0);

    // 2: INCR read, rready held
    clear();
    ar_send(20'h100, 8'd3, 3'd3, 2'd1, 8'h21);
    collect_r(4, 1'b0);
    chk_incr_read("t2", 1'b1);
    chk("t2_rid", rd_i[3], 8'h21);

    // 3: INCR read, rready toggling
    clear();
    ar_send(20'h100, 8'd3, 3'd3, 2'd1, 8'h22);
    collect_r(4, 1'b1);
    repeat (3) tick();
    chk_incr_read("t3", 1'b0);
    chk("t3_stable", 64'(stab_err), 0);
    chk("t3_re_cnt", 64'(re_q.size()), 4);
    chk("t3_beat_cnt", 64'(rd_d.size()), 4);

    // 4: simultaneous AW/AR, twice
    clear();
    awaddr = 20'h200; awlen = 0; awsize = 3; awburst = 1; awid = 8'h31; awvalid = 1'b1;
    araddr = 20'h108; arlen = 0; arsize = 3; arburst = 1; arid = 8'h32; arvalid = 1'b1;
    tick();
    chk("t4_r1_pick", {awready, arready}, 2'b10);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    w_beat(64'hA1A2A3A4A5A6A7A8, 8'hFF, 1'b1);
    model[8'h40] = 64'hA1A2A3A4A5A6A7A8;
    wait_b();
    awvalid = 1'b1; arvalid = 1'b1;
    tick();
    chk("t4_r2_pick", {awready, arready}, 2'b01);
    tick();
    awvalid = 1'b0; arvalid = 1'b0;
    collect_r(1, 1'b0);
    chk("t4_rdata", rd_d[0], model[8'h21]);
    chk("t4_rid", rd_i[0], 8'h32);
    chk("t4_we_addr", we_a[0], 17'h40);

    // 5: WRAP read
    clear();
    ar_send(20'h118, 8'd3, 3'd3, 2'd2, 8'h41);
    collect_r(4, 1'b0);
`ifdef AXI_SRAM_BRIDGE_WRAP_EN
    chk("t5_addr0", re_q[0], 17'h23);
    chk("t5_addr1", re_q[1], 17'h20);
    chk("t5_addr2", re_q[2], 17'h21);
    chk("t5_addr3", re_q[3], 17'h22);
    chk("t5_data0", rd_d[0], model[8'h23]);
    chk("t5_data1", rd_d[1], model[8'h20]);
    chk("t5_resp", rd_r[3], 2'd0);
`else
    chk("t5_re_cnt", 64'(re_q.size()), 0);
    for (int i = 0; i < 4; i++) begin
      chk("t5_resp", rd_r[i], 2'd2);
      chk("t5_last", rd_l[i], i == 3);
    end
`endif

    // FIXED read repeats the same word
    clear();
    ar_send(20'h108, 8'd1, 3'd3, 2'd0, 8'h51);
    collect_r(2, 1'b0);
    chk("fixed_addr0", re_q[0], 17'h21);
    chk("fixed_addr1", re_q[1], 17'h21);
    chk("fixed_data1", rd_d[1], model[8'h21]);

    // INCR wraps at the top of the address space
    clear();
    ar_send(20'hFFFF8, 8'd1, 3'd3, 2'd1, 8'h52);
    collect_r(2, 1'b0);
    chk("top_addr0", re_q[0], 17'h1FFFF);
    chk("top_addr1", re_q[1], 17'h00000);
    chk("top_data1", rd_d[1], model[0]);

    // oversize write: accepted, no SRAM write, SLVERR
    clear();
    aw_send(20'h180, 8'd0, 3'd4, 2'd1, 8'h09);
    w_beat(64'hDEAD, 8'hFF, 1'b1);
    wait_b();
    chk("err_we_cnt", 64'(we_a.size()), 0);
    chk("err_bresp", b_r[0], 2'd2);
    chk("err_bid", b_id[0], 8'h09);

    // 6: reset in the middle of a write burst
    clear();
    aw_send(20'h300, 8'd3, 3'd3, 2'd1, 8'h61);
    w_beat(64'h1, 8'hFF, 1'b0);
    w_beat(64'h2, 8'hFF, 1'b0);
    chk("t6_we_cnt", 64'(we_a.size()), 2);
    areset_n = 1'b0;
    tick(); tick();
    chk_zero_outs("t6_rst");
    areset_n = 1'b1;
    bready = 1'b1;
    repeat (10) tick();
    bready = 1'b0;
    chk("t6_no_bvalid", 64'(bv_cnt), 0);
    clear();
    aw_send(20'h308, 8'd0, 3'd3, 2'd1, 8'h62);
    w_beat(64'h55, 8'h0F, 1'b1);
    wait_b();
    chk("t6_bresp", b_r[0], 2'd0);
    chk("t6_bid", b_id[0], 8'h62);
    chk("t6_we_addr", we_a[0], 17'h61);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
